// File: rtl/max1282_emu.sv
// max1282_emu: SPI-slave stand-in for a MAX1282 4-channel 12-bit ADC.
// Inputs are oversampled on sys_clk. A control word starts a timed conversion,
// then sstrb pulses and the selected channel is shifted out on dout.
module max1282_emu #(
   parameter int unsigned CONV_CYCLES = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cs_n,
   input  logic        sclk,
   input  logic        din,
   input  logic [11:0] ch0_data,
   input  logic [11:0] ch1_data,
   input  logic [11:0] ch2_data,
   input  logic [11:0] ch3_data,
   output logic        dout,
   output logic        sstrb,
   output logic [7:0]  ctrl_word,
   output logic        ctrl_valid,
   output logic        sel_err,
   output logic        pd_mode,
   output logic        abort
);

   localparam int unsigned DATA_W = 12;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned SHR_W  = 15;

   typedef enum logic [2:0] {
      IDLE,
      RX_CTRL,
      CONV,
      STROBE,
      SHIFT
   } state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  cs_sync;
   logic [SYNC_STAGES-1:0]  sclk_sync;
   logic [SYNC_STAGES-1:0]  din_sync;
   logic                    sclk_q;
   logic                    cs_s;
   logic                    sclk_s;
   logic                    din_s;
   logic                    sclk_rise;
   logic                    sclk_fall;
   logic [6:0]              ctrl_sr;
   logic [7:0]              ctrl_next;
   logic [2:0]              bit_cnt;
   logic [CNT_W-1:0]        conv_cnt;
   logic [3:0]              fall_cnt;
   logic [DATA_W-1:0]       sample;
   logic [DATA_W-1:0]       sel_data;
   logic                    sel_ok;
   logic [DATA_W-1:0]       code;
   // Bit 15 of the output word goes straight to dout; this holds bits 14..0.
   logic [SHR_W-1:0]        shift_reg;

   // Input synchronizers; cs_n idles high so a reset never looks like a select.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         din_sync  <= '0;
         sclk_q    <= 1'b0;
      end else begin
         cs_sync   <= SYNC_STAGES'({cs_sync, cs_n});
         sclk_sync <= SYNC_STAGES'({sclk_sync, sclk});
         din_sync  <= SYNC_STAGES'({din_sync, din});
         sclk_q    <= sclk_s;
      end
   end

   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign din_s     = din_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign ctrl_next = {ctrl_sr, din_s};

   // Channel decode of the control word being completed.
   always_comb begin
      sel_ok   = 1'b1;
      sel_data = '0;
      case (ctrl_next[6:4])
         3'b001:  sel_data = ch0_data;
         3'b101:  sel_data = ch1_data;
         3'b010:  sel_data = ch2_data;
         3'b110:  sel_data = ch3_data;
         default: sel_ok   = 1'b0;
      endcase
   end

   // Bipolar mode flips the MSB to turn offset binary into two's complement.
   assign code = ctrl_word[3] ? sample : (sample ^ 12'h800);

   // Frame FSM with registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         dout       <= 1'b0;
         sstrb      <= 1'b0;
         ctrl_word  <= '0;
         ctrl_valid <= 1'b0;
         sel_err    <= 1'b0;
         pd_mode    <= 1'b0;
         abort      <= 1'b0;
         ctrl_sr    <= '0;
         bit_cnt    <= '0;
         conv_cnt   <= '0;
         fall_cnt   <= '0;
         sample     <= '0;
         shift_reg  <= '0;
      end else begin
         ctrl_valid <= 1'b0;
         abort      <= 1'b0;
         if (state != IDLE && cs_s) begin
            // Deselect mid-frame wins over any coincident sclk edge.
            abort <= 1'b1;
            state <= IDLE;
            dout  <= 1'b0;
            sstrb <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  dout  <= 1'b0;
                  sstrb <= 1'b0;
                  if (!cs_s && sclk_rise && din_s) begin
                     state   <= RX_CTRL;
                     bit_cnt <= 3'd1;
                     ctrl_sr <= 7'h01;
                  end
               end
               RX_CTRL: begin
                  if (sclk_rise) begin
                     ctrl_sr <= ctrl_next[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        ctrl_word  <= ctrl_next;
                        ctrl_valid <= 1'b1;
                        sel_err    <= ~sel_ok;
                        pd_mode    <= (ctrl_next[1:0] == 2'b00);
                        conv_cnt   <= '0;
                        if (ctrl_next[1:0] == 2'b00) begin
                           state <= IDLE;
                        end else begin
                           sample <= sel_data;
                           state  <= CONV;
                        end
                     end
                  end
               end
               CONV: begin
                  if (conv_cnt == CNT_W'(CONV_CYCLES)) begin
                     state     <= STROBE;
                     sstrb     <= 1'b1;
                     dout      <= code[11];
                     shift_reg <= {code[10:0], 4'b0000};
                  end else begin
                     conv_cnt <= conv_cnt + CNT_W'(1);
                  end
               end
               STROBE: begin
                  sstrb    <= 1'b0;
                  fall_cnt <= '0;
                  state    <= SHIFT;
               end
               SHIFT: begin
                  if (sclk_fall) begin
                     dout      <= shift_reg[SHR_W-1];
                     shift_reg <= {shift_reg[SHR_W-2:0], 1'b0};
                     fall_cnt  <= fall_cnt + 4'd1;
                     if (fall_cnt == 4'd15) begin
                        state <= IDLE;
                        dout  <= 1'b0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
